// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for an in-order pipeline: one countdown per architectural
// register tracks how many cycles remain until its pending result can be
// forwarded. Produces the data-stall, PC / IF-ID enables, the ID/EX bubble
// control and a saturating count of data-stall cycles.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = 4,
    parameter int SCW     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [AW-1:0]                    id_rs1,
    input  logic [AW-1:0]                    id_rs2,
    input  logic                             id_rs1_used,
    input  logic                             id_rs2_used,
    input  logic                             id_valid,
    input  logic [AW-1:0]                    id_rd,
    input  logic                             id_regwrite,
    input  logic [$clog2(MAX_LAT+1)-1:0]     id_lat,
    input  logic                             branch_flush,
    input  logic                             mem_busy,
    output logic                             stall,
    output logic                             pc_write,
    output logic                             if_id_write,
    output logic                             id_ex_flush,
    output logic [NREG-1:0]                  pending,
    output logic [SCW-1:0]                   stall_cycles
);

    localparam int CW = $clog2(MAX_LAT + 1);

    // Entry 0 is held at zero so x0 never reports a pending result.
    logic [NREG-1:0][CW-1:0] cnt_q;

    logic          rs1_hit;
    logic          rs2_hit;
    logic          issue;
    logic          do_load;
    logic [CW-1:0] lat_clamped;

    // Source-operand hazard detection and issue qualification.
    always_comb begin
        rs1_hit     = id_rs1_used && (id_rs1 != '0) && (cnt_q[id_rs1] != '0);
        rs2_hit     = id_rs2_used && (id_rs2 != '0) && (cnt_q[id_rs2] != '0);
        stall       = id_valid && (rs1_hit || rs2_hit);
        issue       = id_valid && !stall && !mem_busy && !branch_flush;
        do_load     = issue && id_regwrite && (id_rd != '0);
        lat_clamped = (id_lat > CW'(MAX_LAT)) ? CW'(MAX_LAT) : id_lat;
    end

    // Pipeline enables derived from the stall, freeze and flush conditions.
    always_comb begin
        pc_write    = !mem_busy && (!stall || branch_flush);
        if_id_write = !mem_busy && !stall;
        id_ex_flush = !mem_busy && (stall || branch_flush || !id_valid);
    end

    // Per-register pending flags.
    always_comb begin
        pending = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            pending[r] = (cnt_q[r] != '0);
        end
    end

    // Countdown update: a new issue to rd overrides the decrement of that
    // register; everything holds while the memory freezes the pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (r == 0) begin
                    cnt_q[r] <= '0;
                end else if (do_load && (id_rd == AW'(r))) begin
                    cnt_q[r] <= lat_clamped;
                end else if (!mem_busy && (cnt_q[r] != '0)) begin
                    cnt_q[r] <= cnt_q[r] - CW'(1);
                end
            end
        end
    end

    // Saturating count of cycles lost to data hazards (frozen cycles excluded).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && !mem_busy && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + SCW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard: one task per scenario, each with
// hand-computed expectations. A second instance with a 2-bit stall counter
// shares the inputs to exercise counter saturation.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic        id_valid;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic [2:0]  id_lat;
    logic        branch_flush;
    logic        mem_busy;

    logic        stall;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_flush;
    logic [31:0] pending;
    logic [15:0] stall_cycles;

    logic        s_stall;
    logic        s_pc_write;
    logic        s_if_id_write;
    logic        s_id_ex_flush;
    logic [31:0] s_pending;
    logic [1:0]  s_stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_scoreboard u_dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_valid     (id_valid),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_lat       (id_lat),
        .branch_flush (branch_flush),
        .mem_busy     (mem_busy),
        .stall        (stall),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_flush  (id_ex_flush),
        .pending      (pending),
        .stall_cycles (stall_cycles)
    );

    hazard_scoreboard #(.SCW(2)) u_sat (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_valid     (id_valid),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_lat       (id_lat),
        .branch_flush (branch_flush),
        .mem_busy     (mem_busy),
        .stall        (s_stall),
        .pc_write     (s_pc_write),
        .if_id_write  (s_if_id_write),
        .id_ex_flush  (s_id_ex_flush),
        .pending      (s_pending),
        .stall_cycles (s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic rw, input logic [2:0] lat);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_lat      = lat;
    endtask

    task automatic apply_reset;
        reset        = 1'b1;
        branch_flush = 1'b0;
        mem_busy     = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        branch_flush = 1'b0;
        mem_busy     = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL rst_pending: got %h want 0", pending); end
        n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL rst_pc_write: got %b want 1", pc_write); end
        n_cmp++; if (if_id_write !== 1'b1) begin n_bad++; $display("FAIL rst_if_id_write: got %b want 1", if_id_write); end
        n_cmp++; if (id_ex_flush !== 1'b1) begin n_bad++; $display("FAIL rst_id_ex_flush: got %b want 1", id_ex_flush); end
        n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL rst_stall_cycles: got %0d want 0", stall_cycles); end
        tick;
        reset = 1'b0;
    endtask

    task automatic test_load_use;
        apply_reset;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd1);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_load_stall: got %b want 0", stall); end
        n_cmp++; if (id_ex_flush !== 1'b0) begin n_bad++; $display("FAIL lu_load_flush: got %b want 0", id_ex_flush); end
        tick;
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3'd0);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", stall); end
        n_cmp++; if (id_ex_flush !== 1'b1) begin n_bad++; $display("FAIL lu_flush: got %b want 1", id_ex_flush); end
        n_cmp++; if (pc_write !== 1'b0) begin n_bad++; $display("FAIL lu_pc_write: got %b want 0", pc_write); end
        n_cmp++; if (if_id_write !== 1'b0) begin n_bad++; $display("FAIL lu_if_id_write: got %b want 0", if_id_write); end
        n_cmp++; if (pending !== 32'h0000_0020) begin n_bad++; $display("FAIL lu_pending: got %h want 00000020", pending); end
        tick;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_release: got %b want 0", stall); end
        n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL lu_release_pc: got %b want 1", pc_write); end
        n_cmp++; if (stall_cycles !== 16'd1) begin n_bad++; $display("FAIL lu_stall_cycles: got %0d want 1", stall_cycles); end
        tick;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        #1;
        n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL lu_alu_pending: got %h want 0", pending); end
    endtask

    task automatic test_x0_unused;
        apply_reset;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd1);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL x0_load_stall: got %b want 0", stall); end
        tick;
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 3'd2);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL x0_use_stall: got %b want 0", stall); end
        n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL x0_pending: got %h want 0", pending); end
        tick;
        drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 3'd0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL unused_stall: got %b want 0", stall); end
        n_cmp++; if (pending !== 32'h0000_0080) begin n_bad++; $display("FAIL unused_pending: got %h want 00000080", pending); end
        tick;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        #1;
        n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL x0_stall_cycles: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_multicycle;
        apply_reset;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd4);
        tick;
        drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (stall !== (i < 4)) begin n_bad++; $display("FAIL mc4_stall[%0d]: got %b want %b", i, stall, (i < 4)); end
            tick;
        end
        n_cmp++; if (stall_cycles !== 16'd4) begin n_bad++; $display("FAIL mc4_stall_cycles: got %0d want 4", stall_cycles); end
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd7);
        tick;
        drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (stall !== (i < 4)) begin n_bad++; $display("FAIL mc7_stall[%0d]: got %b want %b", i, stall, (i < 4)); end
            tick;
        end
        n_cmp++; if (stall_cycles !== 16'd8) begin n_bad++; $display("FAIL mc7_stall_cycles: got %0d want 8", stall_cycles); end
    endtask

    task automatic test_freeze;
        apply_reset;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 3'd2);
        tick;
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (pending !== 32'h0000_0400) begin n_bad++; $display("FAIL frz_pending[%0d]: got %h want 00000400", i, pending); end
            n_cmp++; if (pc_write !== 1'b0) begin n_bad++; $display("FAIL frz_pc_write[%0d]: got %b want 0", i, pc_write); end
            n_cmp++; if (if_id_write !== 1'b0) begin n_bad++; $display("FAIL frz_if_id_write[%0d]: got %b want 0", i, if_id_write); end
            n_cmp++; if (id_ex_flush !== 1'b0) begin n_bad++; $display("FAIL frz_id_ex_flush[%0d]: got %b want 0", i, id_ex_flush); end
            n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL frz_stall_cycles[%0d]: got %0d want 0", i, stall_cycles); end
            tick;
        end
        mem_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (stall !== (i < 2)) begin n_bad++; $display("FAIL frz_release_stall[%0d]: got %b want %b", i, stall, (i < 2)); end
            tick;
        end
        n_cmp++; if (stall_cycles !== 16'd2) begin n_bad++; $display("FAIL frz_final_cycles: got %0d want 2", stall_cycles); end
    endtask

    task automatic test_branch_during_stall;
        apply_reset;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 3'd3);
        tick;
        drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 3'd2);
        branch_flush = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL br_stall: got %b want 1", stall); end
        n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL br_pc_write: got %b want 1", pc_write); end
        n_cmp++; if (if_id_write !== 1'b0) begin n_bad++; $display("FAIL br_if_id_write: got %b want 0", if_id_write); end
        n_cmp++; if (id_ex_flush !== 1'b1) begin n_bad++; $display("FAIL br_id_ex_flush: got %b want 1", id_ex_flush); end
        tick;
        branch_flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        #1;
        n_cmp++; if (pending !== 32'h0000_1000) begin n_bad++; $display("FAIL br_pending_a: got %h want 00001000", pending); end
        n_cmp++; if (stall_cycles !== 16'd1) begin n_bad++; $display("FAIL br_stall_cycles: got %0d want 1", stall_cycles); end
        tick;
        n_cmp++; if (pending !== 32'h0000_1000) begin n_bad++; $display("FAIL br_pending_b: got %h want 00001000", pending); end
        tick;
        n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL br_pending_c: got %h want 0", pending); end
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 3'd2);
        branch_flush = 1'b1;
        #1;
        n_cmp++; if (id_ex_flush !== 1'b1) begin n_bad++; $display("FAIL br_nostall_flush: got %b want 1", id_ex_flush); end
        tick;
        branch_flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        #1;
        n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL br_no_load: got %h want 0", pending); end
    endtask

    task automatic test_reset_mid;
        apply_reset;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd3);
        tick;
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rm_pre_stall: got %b want 1", stall); end
        n_cmp++; if (pending !== 32'h0000_0008) begin n_bad++; $display("FAIL rm_pre_pending: got %h want 00000008", pending); end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL rm_async_pending: got %h want 0", pending); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rm_async_stall: got %b want 0", stall); end
        n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL rm_async_pc_write: got %b want 1", pc_write); end
        tick;
        reset = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rm_post_stall: got %b want 0", stall); end
        tick;
        n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL rm_stall_cycles: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_back_to_back;
        apply_reset;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 3'd0);
        tick;
        drive(1'b1, 5'd0, 1'b0, 5'd21, 1'b1, 5'd20, 1'b1, 3'd2);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_alu_stall: got %b want 0", stall); end
        tick;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 3'd4);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_reissue_stall: got %b want 0", stall); end
        tick;
        drive(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (stall !== (i < 4)) begin n_bad++; $display("FAIL b2b_stall[%0d]: got %b want %b", i, stall, (i < 4)); end
            tick;
        end
        n_cmp++; if (stall_cycles !== 16'd4) begin n_bad++; $display("FAIL b2b_stall_cycles: got %0d want 4", stall_cycles); end
    endtask

    task automatic test_saturation;
        logic [1:0] exp_sat;
        apply_reset;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd4);
        tick;
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            exp_sat = (i <= 3) ? 2'(i) : 2'd3;
            #1;
            n_cmp++; if (s_stall_cycles !== exp_sat) begin n_bad++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, s_stall_cycles, exp_sat); end
            tick;
        end
        n_cmp++; if (s_stall_cycles !== 2'd3) begin n_bad++; $display("FAIL sat_final: got %0d want 3", s_stall_cycles); end
        n_cmp++; if (stall_cycles !== 16'd4) begin n_bad++; $display("FAIL sat_wide_count: got %0d want 4", stall_cycles); end
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_x0_unused;
        test_multicycle;
        test_freeze;
        test_branch_during_stall;
        test_reset_mid;
        test_back_to_back;
        test_saturation;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
